irq_arbiter: RTL

IRQ_ARBITER -- requirements
Module: irq_arbiter

---
 rtl/irq_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: pending bits, highest-priority selection above a threshold, and a
// single offer/claim/complete handshake with the core (no nesting).
module irq_arbiter #(
    parameter int NrInputs  = 32,
    parameter int PrioWidth = 4,
    parameter int IdWidth   = $clog2(NrInputs)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NrInputs-1:0]           irq_pulse_i,
    input  logic [NrInputs-1:0]           ie_i,
    input  logic [NrInputs*PrioWidth-1:0] prio_i,
    input  logic [PrioWidth-1:0]          threshold_i,
    output logic [NrInputs-1:0]           ip_o,
    output logic                          irq_valid_o,
    output logic [IdWidth-1:0]            irq_id_o,
    output logic [PrioWidth-1:0]          irq_prio_o,
    input  logic                          irq_ready_i,
    input  logic                          complete_valid_i,
    input  logic [IdWidth-1:0]            complete_id_i,
    output logic                          active_o,
    output logic [IdWidth-1:0]            active_id_o,
    output logic                          complete_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        ACTIVE
    } state_e;

    state_e               state_q, state_d;
    logic [NrInputs-1:0]  ip_q, ip_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [PrioWidth-1:0] prio_q, prio_d;
    logic [IdWidth-1:0]   active_id_q, active_id_d;
    logic                 err_q, err_d;

    logic                 win_found;
    logic [IdWidth-1:0]   win_id;
    logic [PrioWidth-1:0] win_prio;
    logic                 claim;

    // Seeding the running best with the threshold makes "strictly above threshold"
    // and "strictly better than earlier lines" the same test, so ties keep the lowest index.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_prio  = threshold_i;
        for (int i = 0; i < NrInputs; i++) begin
            if (ip_q[i] && ie_i[i] && (prio_i[i*PrioWidth +: PrioWidth] > win_prio)) begin
                win_found = 1'b1;
                win_id    = IdWidth'(i);
                win_prio  = prio_i[i*PrioWidth +: PrioWidth];
            end
        end
    end

    assign claim = (state_q == OFFER) && irq_ready_i;

    // A new pulse on the claimed line in the claim cycle keeps it pending.
    always_comb begin
        ip_d = ip_q;
        if (claim) begin
            ip_d[id_q] = 1'b0;
        end
        ip_d = ip_d | irq_pulse_i;
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        prio_d      = prio_q;
        active_id_d = active_id_q;
        err_d       = complete_valid_i;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = OFFER;
                    id_d    = win_id;
                    prio_d  = win_prio;
                end
            end
            OFFER: begin
                if (irq_ready_i) begin
                    state_d     = ACTIVE;
                    active_id_d = id_q;
                end
            end
            ACTIVE: begin
                if (complete_valid_i && (complete_id_i == active_id_q)) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ip_q        <= '0;
            id_q        <= '0;
            prio_q      <= '0;
            active_id_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            id_q        <= id_d;
            prio_q      <= prio_d;
            active_id_q <= active_id_d;
            err_q       <= err_d;
        end
    end

    assign ip_o           = ip_q;
    assign irq_valid_o    = (state_q == OFFER);
    assign irq_id_o       = irq_valid_o ? id_q : '0;
    assign irq_prio_o     = irq_valid_o ? prio_q : '0;
    assign active_o       = (state_q == ACTIVE);
    assign active_id_o    = active_o ? active_id_q : '0;
    assign complete_err_o = err_q;

endmodule
